// File: rtl/seg7_pkg.sv
// seg7_pkg: shared register map, idle output codes and segment table
// for the memory-mapped seven-segment display blocks.
package seg7_pkg;

  localparam logic [7:0] DIGITS_LO_OFS = 8'd0;
  localparam logic [7:0] DIGITS_HI_OFS = 8'd1;
  localparam logic [7:0] CTRL_OFS      = 8'd2;

  localparam logic [7:0] CTRL_RESET = 8'hF0;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  // Active-low cathodes, bit order g..a; b and d are lower-case.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: nibble + dot enable -> 8-bit active-low cathodes.
// Ports: nibble[3:0], dot (1 = lit), pattern[7:0] ({dp, g..a}).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  output logic [7:0] pattern
);

  assign pattern = {~dot, SEG_PATTERNS[nibble]};

endmodule

// File: rtl/seg7_bus_display.sv
// seg7_bus_display: bus-written 3-register display peripheral that
// time-multiplexes four hex digits onto a common-anode display.
// Ports: CLK, RESET (async, high), BUS_DATA (inout), BUS_ADDR, BUS_WE,
// SEG_SELECT_OUT (active-low anodes), HEX_OUT (active-low {dp,g..a}).
// Option: define SEG7_READBACK_EN to drive register values on reads.
module seg7_bus_display
  import seg7_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [7:0]    digits_lo;
  logic [7:0]    digits_hi;
  logic [7:0]    ctrl;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  // Modulo-256 offset keeps the decode correct near the top of the map.
  logic [7:0] ofs;
  logic       wr_lo;
  logic       wr_hi;
  logic       wr_ctrl;

  assign ofs     = BUS_ADDR - BASE_ADDR;
  assign wr_lo   = BUS_WE && (ofs == DIGITS_LO_OFS);
  assign wr_hi   = BUS_WE && (ofs == DIGITS_HI_OFS);
  assign wr_ctrl = BUS_WE && (ofs == CTRL_OFS);

  logic [3:0] nibble;
  logic       dot;
  logic       blank;
  logic [7:0] pattern;

  always_comb begin
    nibble = digits_lo[3:0];
    unique case (idx)
      2'd0: nibble = digits_lo[3:0];
      2'd1: nibble = digits_lo[7:4];
      2'd2: nibble = digits_hi[3:0];
      2'd3: nibble = digits_hi[7:4];
    endcase
  end

  assign dot   = ctrl[idx];
  assign blank = ctrl[{1'b1, idx}];

  seg7_hex_decoder u_dec (
    .nibble  (nibble),
    .dot     (dot),
    .pattern (pattern)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt            <= '0;
      idx            <= '0;
      digits_lo      <= '0;
      digits_hi      <= '0;
      ctrl           <= CTRL_RESET;
      SEG_SELECT_OUT <= ANODES_OFF;
      HEX_OUT        <= SEG_BLANK;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (wr_lo)   digits_lo <= BUS_DATA;
      if (wr_hi)   digits_hi <= BUS_DATA;
      if (wr_ctrl) ctrl      <= BUS_DATA;
      // Blanked slots still burn their time so brightness stays even.
      if (blank) begin
        SEG_SELECT_OUT <= ANODES_OFF;
        HEX_OUT        <= SEG_BLANK;
      end else begin
        SEG_SELECT_OUT <= ~(4'b0001 << idx);
        HEX_OUT        <= pattern;
      end
    end
  end

`ifdef SEG7_READBACK_EN
  logic [7:0] rdata;
  logic       rd_en;

  always_comb begin
    rdata = 8'h00;
    rd_en = 1'b0;
    unique case (1'b1)
      ofs == DIGITS_LO_OFS: begin rdata = digits_lo; rd_en = 1'b1; end
      ofs == DIGITS_HI_OFS: begin rdata = digits_hi; rd_en = 1'b1; end
      ofs == CTRL_OFS:      begin rdata = ctrl;      rd_en = 1'b1; end
      default: ;
    endcase
  end

  assign BUS_DATA = (!BUS_WE && rd_en) ? rdata : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule

// File: tb/tb_seg7_bus_display.sv
// tb_seg7_bus_display: randomized and directed checks of the display
// peripheral against an arithmetic scan model.
module tb_seg7_bus_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       we = 1'b0;
  logic       drv = 1'b0;
  logic [7:0] val = 8'h00;
  wire  [7:0] bus_data;
  logic [3:0] sel;
  logic [7:0] hex;

  int errors = 0;
  int checks = 0;

  assign bus_data = drv ? val : 8'hzz;

  // A floating bus reads back as all ones.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus_data[i]);
  end

  always #5 clk = ~clk;

  seg7_bus_display #(
    .BASE_ADDR   (8'hD0),
    .REFRESH_DIV (DIV)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .BUS_DATA       (bus_data),
    .BUS_ADDR       (addr),
    .BUS_WE         (we),
    .SEG_SELECT_OUT (sel),
    .HEX_OUT        (hex)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Model: slot number = edges since reset / DIV; output after an edge
  // shows the register contents and slot from before that edge.
  logic [7:0]  m_reg [3];
  int unsigned m_n;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_hex;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     <= 0;
      m_reg   <= '{8'h00, 8'h00, 8'hF0};
      exp_sel <= 4'hF;
      exp_hex <= 8'hFF;
    end else begin
      int d;
      logic [15:0] digs;
      d = (m_n / DIV) % 4;
      digs = {m_reg[1], m_reg[0]};
      if (m_reg[2][4 + d]) begin
        exp_sel <= 4'hF;
        exp_hex <= 8'hFF;
      end else begin
        exp_sel <= ~(4'b0001 << d);
        exp_hex <= {~m_reg[2][d], seg_of(digs[4*d +: 4])};
      end
      if (we && addr >= 8'hD0 && addr <= 8'hD2) m_reg[addr - 8'hD0] <= val;
      m_n <= m_n + 1;
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; val = d; we = 1'b1; drv = 1'b1;
    @(negedge clk);
    we = 1'b0; drv = 1'b0;
  endtask

  task automatic test_reset;
    bus_write(8'hD2, 8'h00);
    bus_write(8'hD0, 8'h21);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sel !== 4'hF || hex !== 8'hFF) begin
      errors++;
      $display("FAIL reset_async: sel=%h hex=%h expected F FF", sel, hex);
    end
    @(negedge clk);
    rst = 1'b0;
    addr = 8'hD0; we = 1'b0; drv = 1'b0;
    for (int r = 0; r < 3; r++) begin
      logic [7:0] e;
      addr = 8'hD0 + 8'(r);
      #1;
`ifdef SEG7_READBACK_EN
      e = (r == 2) ? 8'hF0 : 8'h00;
`else
      e = 8'hFF;
`endif
      checks++;
      if (bus_data !== e) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h expected %h", r, bus_data, e);
      end
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (sel !== 4'hF || hex !== 8'hFF) begin
        errors++;
        $display("FAIL reset_blank: sel=%h hex=%h", sel, hex);
      end
    end
  endtask

  task automatic test_basic_scan;
    int e_cnt = 0;
    bus_write(8'hD0, 8'h21);
    bus_write(8'hD1, 8'h43);
    bus_write(8'hD2, 8'h00);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      logic [7:0] want;
      @(negedge clk);
      checks++;
      if (sel !== exp_sel || hex !== exp_hex) begin
        errors++;
        $display("FAIL scan: sel=%h hex=%h expected %h %h", sel, hex, exp_sel, exp_hex);
      end
      case (sel)
        4'hE: want = 8'hF9;
        4'hD: want = 8'hA4;
        4'hB: want = 8'hB0;
        4'h7: want = 8'h99;
        default: want = 8'h00;
      endcase
      checks++;
      if (hex !== want) begin
        errors++;
        $display("FAIL scan_digit: sel=%h hex=%h expected %h", sel, hex, want);
      end
      if (c < 16 && sel === 4'hE) e_cnt++;
    end
    checks++;
    if (e_cnt != DIV) begin
      errors++;
      $display("FAIL scan_hold: digit0 cycles=%0d expected %0d", e_cnt, DIV);
    end
  endtask

  task automatic test_blank_dot;
    int blanks = 0;
    bus_write(8'hD2, 8'h41);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== exp_sel || hex !== exp_hex) begin
        errors++;
        $display("FAIL blank: sel=%h hex=%h expected %h %h", sel, hex, exp_sel, exp_hex);
      end
      if (sel === 4'hE) begin
        checks++;
        if (hex[7] !== 1'b0) begin
          errors++;
          $display("FAIL dot0: hex=%h expected dp low", hex);
        end
      end
      if (c < 16 && sel === 4'hF) begin
        blanks++;
        checks++;
        if (hex !== 8'hFF) begin
          errors++;
          $display("FAIL blank_hex: hex=%h expected FF", hex);
        end
      end
    end
    checks++;
    if (blanks != DIV) begin
      errors++;
      $display("FAIL blank_slot: blank cycles=%0d expected %0d", blanks, DIV);
    end
  endtask

  task automatic test_hex_decode;
    bus_write(8'hD0, 8'hFE);
    bus_write(8'hD1, 8'hDC);
    bus_write(8'hD2, 8'h00);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      logic [7:0] want;
      @(negedge clk);
      case (sel)
        4'hE: want = 8'h86;
        4'hD: want = 8'h8E;
        4'hB: want = 8'hC6;
        4'h7: want = 8'hA1;
        default: want = 8'h00;
      endcase
      checks++;
      if (hex !== want || sel !== exp_sel) begin
        errors++;
        $display("FAIL decode: sel=%h hex=%h expected %h %h", sel, hex, exp_sel, want);
      end
    end
  endtask

  task automatic test_write_timing;
    int guard;
    bus_write(8'hD0, 8'h21);
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (m_n % 16 != 0 && guard < 100);
    addr = 8'hD0; val = 8'h05; we = 1'b1; drv = 1'b1;
    @(negedge clk);
    we = 1'b0; drv = 1'b0;
    checks++;
    if (sel !== 4'hE || hex !== 8'hF9) begin
      errors++;
      $display("FAIL wr_edge_k: sel=%h hex=%h expected E F9", sel, hex);
    end
    @(negedge clk);
    checks++;
    if (sel !== 4'hE || hex !== 8'h92) begin
      errors++;
      $display("FAIL wr_edge_k1: sel=%h hex=%h expected E 92", sel, hex);
    end
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (m_n % 16 != 3 && guard < 100);
    addr = 8'hD0; val = 8'h75; we = 1'b1; drv = 1'b1;
    @(negedge clk);
    we = 1'b0; drv = 1'b0;
    checks++;
    if (sel !== 4'hE || hex !== 8'h92) begin
      errors++;
      $display("FAIL wrap_k: sel=%h hex=%h expected E 92", sel, hex);
    end
    @(negedge clk);
    checks++;
    if (sel !== 4'hD || hex !== 8'hF8) begin
      errors++;
      $display("FAIL wrap_k1: sel=%h hex=%h expected D F8", sel, hex);
    end
  endtask

  task automatic test_bus_isolation;
    logic [7:0] e;
    bus_write(8'hD1, 8'h43);
    bus_write(8'hD3, 8'h55);
    bus_write(8'hE0, 8'h55);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== exp_sel || hex !== exp_hex) begin
        errors++;
        $display("FAIL isolate: sel=%h hex=%h expected %h %h", sel, hex, exp_sel, exp_hex);
      end
    end
    addr = 8'hD1; we = 1'b1; drv = 1'b0;
    #1;
    checks++;
    if (bus_data !== 8'hFF) begin
      errors++;
      $display("FAIL write_float: bus=%h expected float FF", bus_data);
    end
    we = 1'b0;
    #1;
`ifdef SEG7_READBACK_EN
    e = 8'h43;
`else
    e = 8'hFF;
`endif
    checks++;
    if (bus_data !== e) begin
      errors++;
      $display("FAIL read_d1: bus=%h expected %h", bus_data, e);
    end
    addr = 8'hE0;
    #1;
    checks++;
    if (bus_data !== 8'hFF) begin
      errors++;
      $display("FAIL unmapped_float: bus=%h expected FF", bus_data);
    end
    addr = 8'h00;
  endtask

  task automatic test_random;
    logic [7:0] pick [6];
    pick = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hCF};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== exp_sel || hex !== exp_hex) begin
        errors++;
        $display("FAIL random c%0d: sel=%h hex=%h expected %h %h", c, sel, hex, exp_sel, exp_hex);
      end
      if ($urandom_range(3) == 0) begin
        addr = pick[$urandom_range(5)];
        val  = 8'($urandom);
        we = 1'b1; drv = 1'b1;
      end else begin
        we = 1'b0; drv = 1'b0;
      end
    end
    we = 1'b0; drv = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_basic_scan;
    test_blank_dot;
    test_hex_decode;
    test_write_timing;
    test_bus_isolation;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_bus_display.md
Name: seg7_bus_display

Overview:
- Processor-bus write-side peripheral. The processor writes hex digits and control bits into memory-mapped registers.
- The block time-multiplexes those registers onto a 4-digit common-anode seven-segment display.
- It sits on the shared BUS_DATA/BUS_ADDR/BUS_WE bus beside the input peripherals and is the output counterpart of the switch read port.

Parameters:
- BASE_ADDR, 8'hD0, address of DIGITS_LO. DIGITS_HI is at BASE_ADDR+1 and CTRL at BASE_ADDR+2.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range is 2..2^20.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  processor data bus; sampled on writes, driven only when SEG7_READBACK_EN is set.
- BUS_ADDR  input  8  processor address bus.
- BUS_WE  input  1  1 = write cycle, 0 = read cycle.
- SEG_SELECT_OUT  output  4  active-low digit anodes; bit i = digit i.
- HEX_OUT  output  8  active-low cathodes; [6:0] = segments g..a, [7] = decimal point.

Behaviour:
- Registers and reset values:
  - DIGITS_LO: [3:0] = digit0, [7:4] = digit1; reset 8'h00.
  - DIGITS_HI: [3:0] = digit2, [7:4] = digit3; reset 8'h00.
  - CTRL: [3:0] = dot enable per digit, [7:4] = blank per digit; reset 8'hF0 (all blanked).
- Write: on a rising edge with BUS_WE=1 and BUS_ADDR in BASE_ADDR..BASE_ADDR+2, the addressed register loads BUS_DATA.
  - Writes to any other address are ignored.
  - Each register holds its value until the next write or reset.
- Scan counter: runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - Both reset to 0.
- Output register: each edge, SEG_SELECT_OUT and HEX_OUT are loaded from the index, DIGITS and CTRL values present before that edge.
  - Write on edge k to the currently scanned digit → visible after edge k+1.
  - Write and index advance on the same edge both take effect; the new index/value pair appears one edge later.
- Unblanked digit i:
  - SEG_SELECT_OUT = ~(4'b0001 << i).
  - HEX_OUT[6:0] = active-low hex pattern of the nibble; all of 0-F are decoded, with b and d lower-case.
  - HEX_OUT[7] = ~CTRL[i].
- Blanked digit i: SEG_SELECT_OUT = 4'hF and HEX_OUT = 8'hFF for that entire slot. The slot is still consumed, so scan period and brightness stay constant.
- Reset values of outputs: SEG_SELECT_OUT = 4'hF, HEX_OUT = 8'hFF.
  - First lit output is possible only after CTRL is written with a blank bit cleared.
  - Reset mid-slot returns the counter and index to 0 immediately, outputs included.
- Bus drive: the block never drives BUS_DATA during a write cycle or for an unmapped address.

Optional Feature:
- Macro: SEG7_READBACK_EN.
- Defined: when BUS_WE=0 and BUS_ADDR matches one of the three registers, BUS_DATA is combinationally driven with that register's value; otherwise it is 8'hZZ.
- Undefined: BUS_DATA is permanently 8'hZZ (write-only peripheral), and processor reads of these addresses return bus float.

Decomposition:
- Shared package seg7_pkg holds:
  - register offsets: DIGITS_LO_OFS = 0, DIGITS_HI_OFS = 1, CTRL_OFS = 2;
  - SEG_BLANK = 8'hFF and ANODES_OFF = 4'hF;
  - the 16-entry active-low segment pattern constant.
- One sub-module, seg7_hex_decoder: combinational nibble + dot → 8-bit active-low cathode pattern. It is reused by the other display blocks.

Test Plan:
1. Reset: assert RESET mid-slot. SEG_SELECT_OUT = 4'hF and HEX_OUT = 8'hFF immediately (asynchronous). Read registers (readback build) → 8'h00, 8'h00, 8'hF0.
2. Basic scan, REFRESH_DIV = 4: write 8'h21 to D0, 8'h43 to D1, 8'h00 to D2. Anodes cycle E,D,B,7, each held 4 cycles. Cathodes 8'hF9, 8'hA4, 8'hB0, 8'h99 (1,2,3,4, dot off).
3. Blank and dot: write CTRL = 8'h41. Digit 2 slot shows SEG_SELECT_OUT = 4'hF and HEX_OUT = 8'hFF. Digit 0 shows HEX_OUT[7] = 0. Scan period stays 16 cycles.
4. Hex decode coverage: write 8'hFE to D0, 8'hDC to D1. Digits show E = 8'h86, F = 8'h8E, C = 8'hC6, D = 8'hA1.
5. Write timing: write D0 = 8'h05 while digit 0 is active. HEX_OUT = 8'h92 after edge k+1, unchanged at edge k. Simultaneous write and index wrap shows the new digit with the new value.
6. Bus isolation: a write to 8'hD3 and 8'hE0 leaves registers unchanged. During any write cycle BUS_DATA = Z. Reading D1 drives 8'h43 only when SEG7_READBACK_EN is defined, else Z.
